// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one step per clock, with early completion for divide-by-zero and overflow.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN) + 1;
   localparam int unsigned AW = 2 * XLEN;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   acc;
   logic [XLEN-1:0] mag;
   logic [CW-1:0]   cnt;
   logic            op_div, op_high, op_rem, neg_q, neg_r, special;
   logic [XLEN-1:0] spec_res;
   logic            load, finish;

   // Operand decode, evaluated only when a request is accepted
   logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, is_spec;
   logic [XLEN-1:0] mag_a, mag_b, spec_val;

   assign is_div   = funct3[2];
   assign a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
   assign b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
   assign a_neg    = a_sgn && operand_a[XLEN-1];
   assign b_neg    = b_sgn && operand_b[XLEN-1];
   assign mag_a    = a_neg ? (~operand_a + XLEN'(1)) : operand_a;
   assign mag_b    = b_neg ? (~operand_b + XLEN'(1)) : operand_b;
   assign div_zero = is_div && (operand_b == '0);
   assign div_ovf  = is_div && !funct3[0] && (operand_b == '1) &&
                     (operand_a == {1'b1, {(XLEN-1){1'b0}}});
   assign is_spec  = div_zero || div_ovf;

   always_comb begin
      spec_val = '0;
      if (div_zero)
         spec_val = funct3[1] ? operand_a : '1;
      else if (div_ovf)
         spec_val = funct3[1] ? '0 : operand_a;
   end

   // One iteration step for each operation class
   logic [XLEN-1:0] mul_add;
   logic [XLEN:0]   mul_sum, div_trial;
   logic [AW-1:0]   mul_nxt, div_nxt;
   logic [CW-1:0]   cnt_nxt;

   assign mul_add   = acc[0] ? mag : '0;
   assign mul_sum   = {1'b0, acc[AW-1:XLEN]} + {1'b0, mul_add};
   assign mul_nxt   = {mul_sum, acc[XLEN-1:1]};
   assign div_trial = {acc[AW-1:XLEN], acc[XLEN-1]} - {1'b0, mag};
   assign div_nxt   = div_trial[XLEN] ? {acc[AW-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign cnt_nxt   = cnt + CW'(1);

   // Sign fix-up of the final step's value
   logic [AW-1:0]   prod_s;
   logic [XLEN-1:0] quo_s, rem_s, res_fin;

   assign prod_s = neg_q ? (~mul_nxt + AW'(1)) : mul_nxt;
   assign quo_s  = neg_q ? (~div_nxt[XLEN-1:0] + XLEN'(1)) : div_nxt[XLEN-1:0];
   assign rem_s  = neg_r ? (~div_nxt[AW-1:XLEN] + XLEN'(1)) : div_nxt[AW-1:XLEN];

   always_comb begin
      res_fin = op_high ? prod_s[AW-1:XLEN] : prod_s[XLEN-1:0];
      if (special)
         res_fin = spec_res;
      else if (op_div)
         res_fin = op_rem ? rem_s : quo_s;
   end

   // Next-state logic; flush takes priority over both acceptance and completion
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      finish    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !flush) begin
               state_nxt = S_CALC;
               load      = 1'b1;
            end
         end
         S_CALC: begin
            if (flush)
               state_nxt = S_IDLE;
            else if (cnt_nxt == CW'(XLEN)) begin
               state_nxt = S_DONE;
               finish    = 1'b1;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Special cases reuse CALC for a single cycle by preloading the counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         acc      <= '0;
         mag      <= '0;
         cnt      <= '0;
         op_div   <= 1'b0;
         op_high  <= 1'b0;
         op_rem   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         special  <= 1'b0;
         spec_res <= '0;
      end else begin
         state <= state_nxt;
         ready <= (state_nxt == S_IDLE);
         busy  <= (state_nxt != S_IDLE);
         done  <= (state_nxt == S_DONE);
         if (load) begin
            acc      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            mag      <= is_div ? mag_b : mag_a;
            cnt      <= is_spec ? CW'(XLEN - 1) : '0;
            op_div   <= is_div;
            op_high  <= (funct3[1:0] != 2'b00);
            op_rem   <= funct3[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            special  <= is_spec;
            spec_res <= spec_val;
         end else if (state == S_CALC) begin
            acc <= op_div ? div_nxt : mul_nxt;
            cnt <= cnt_nxt;
         end
         if (finish)
            result <= res_fin;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, special cases,
// busy-start rejection, flush and asynchronous reset.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        flush;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .funct3    (funct3),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .flush     (flush),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, scramble inputs after acceptance, then measure latency and result
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      int bad;
      start     = 1'b1;
      funct3    = f3;
      operand_a = a;
      operand_b = b;
      tick();
      start     = 1'b0;
      operand_a = $urandom;
      operand_b = $urandom;
      funct3    = 3'($urandom);
      lat = 0;
      bad = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1 || ready !== 1'b0) bad++;
         tick();
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, result, exp);
      chk({tag, "_busy"}, 32'(bad), 32'd0);
      tick();
      chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
      chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
   endtask

   initial begin
      int lat;
      int seen;
      rst_n     = 1'b0;
      start     = 1'b0;
      flush     = 1'b0;
      funct3    = 3'b000;
      operand_a = '0;
      operand_b = '0;
      #12;
      chk("rst_ready",  {31'b0, ready}, 32'd1);
      chk("rst_busy",   {31'b0, busy},  32'd0);
      chk("rst_done",   {31'b0, done},  32'd0);
      chk("rst_result", result,         32'd0);
      rst_n = 1'b1;
      tick();

      // Multiplies
      run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32);
      run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
      run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
      run_op("mulh2",  3'b001, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32);

      // Divides
      run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32);
      run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32);
      run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       32);
      run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        32);
      run_op("div_nb", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32);
      run_op("rem_nb", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32);

      // Special cases
      run_op("div_z",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("remu_z", 3'b111, 32'd5,        32'd0,        32'd5,        1);
      run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

      // Start while busy must not disturb the op in flight
      start = 1'b1; funct3 = 3'b000; operand_a = 32'd6; operand_b = 32'd7;
      tick();
      start = 1'b0;
      repeat (4) tick();
      start = 1'b1; funct3 = 3'b101; operand_a = 32'd100; operand_b = 32'd5;
      tick();
      start = 1'b0;
      lat = 5;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      chk("bstart_lat", 32'(lat), 32'd32);
      chk("bstart_res", result,   32'd42);
      tick();

      // Flush mid-calculation
      start = 1'b1; funct3 = 3'b000; operand_a = 32'd9; operand_b = 32'd9;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_ready",  {31'b0, ready}, 32'd1);
      chk("flush_busy",   {31'b0, busy},  32'd0);
      chk("flush_done",   {31'b0, done},  32'd0);
      chk("flush_result", result,         32'd42);
      seen = 0;
      repeat (40) begin
         tick();
         if (done === 1'b1) seen++;
      end
      chk("flush_nodone", 32'(seen), 32'd0);

      // Flush and start together in IDLE: nothing accepted
      flush = 1'b1; start = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd3;
      tick();
      flush = 1'b0; start = 1'b0;
      chk("fs_ready", {31'b0, ready}, 32'd1);
      chk("fs_busy",  {31'b0, busy},  32'd0);

      // Asynchronous reset mid-divide
      start = 1'b1; funct3 = 3'b101; operand_a = 32'd1000; operand_b = 32'd7;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_ready",  {31'b0, ready}, 32'd1);
      chk("arst_busy",   {31'b0, busy},  32'd0);
      chk("arst_done",   {31'b0, done},  32'd0);
      chk("arst_result", result,         32'd0);
      #2;
      rst_n = 1'b1;
      tick();
      run_op("divu_post", 3'b101, 32'd9, 32'd3, 32'd3, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
